fifo_reader: RTL

//  Read-side controller for the common FIFO: issues single-cycle REQ pops, tracks
//  in-flight reads across the FIFO read latency, and captures returned data into a

---
 rtl/fifo_reader.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/fifo_reader.sv
// fifo_reader: read-side controller for the common FIFO.
// Issues single-cycle pops, tracks reads in flight across the FIFO
// read latency, buffers returned data locally and presents it to the
// consumer as a valid/ready stream. It never pops an empty FIFO and
// never overruns its local buffer.
//
// Ports:
//   CLK        in   clock, rising edge
//   RST        in   asynchronous active-high reset
//   FIFO_EMPTY in   registered FIFO empty flag
//   FIFO_C     in   FIFO read data (N bits)
//   FIFO_REQ   out  pop request to the FIFO
//   FLUSH      in   discard buffered and in-flight data
//   OUT_DATA   out  head-of-buffer data (N bits)
//   OUT_VALID  out  OUT_DATA valid
//   OUT_READY  in   consumer accepts on VALID & READY
//   OUT_LEVEL  out  entries held in the local buffer
//   BUSY       out  controller not idle

module fifo_reader #(
    parameter int N         = 8,
    parameter int RD_LAT    = 1,
    parameter int BUF_DEPTH = 4
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           FIFO_EMPTY,
    input  logic [N-1:0]                   FIFO_C,
    output logic                           FIFO_REQ,
    input  logic                           FLUSH,
    output logic [N-1:0]                   OUT_DATA,
    output logic                           OUT_VALID,
    input  logic                           OUT_READY,
    output logic [$clog2(BUF_DEPTH+1)-1:0] OUT_LEVEL,
    output logic                           BUSY
);

    localparam int LW = $clog2(BUF_DEPTH + 1);
    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = $clog2(BUF_DEPTH + RD_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_DRAIN
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    // Bit i set: a pop issued i+1 edges ago is still in flight.
    logic [RD_LAT-1:0] r_sr;
    logic [RD_LAT-1:0] w_sr_nxt;

    logic [N-1:0]    r_buf [BUF_DEPTH];
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [LW-1:0]   r_level;
    logic [LW-1:0]   w_level_nxt;

    logic [CW-1:0]   w_inflight;
    logic [CW-1:0]   w_inflight_nxt;
    logic [CW-1:0]   w_occ;

    logic            w_req;
    logic            w_valid;
    logic            w_pop;
    logic            w_cap;
    logic            w_flush_act;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(BUF_DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            w_inflight = w_inflight + CW'(r_sr[i]);
        end
    end

    // Occupancy counts reads in flight as already owning a buffer
    // slot, so a returning read always finds room.
    always_comb begin
        w_occ = w_inflight + CW'(r_level);
        w_req = !RST && !FIFO_EMPTY && !FLUSH &&
                (r_state != S_DRAIN) &&
                (w_occ < CW'(BUF_DEPTH));
    end

    always_comb begin
        w_sr_nxt    = '0;
        w_sr_nxt[0] = w_req;
        for (int i = 1; i < RD_LAT; i++) begin
            w_sr_nxt[i] = r_sr[i-1];
        end
    end

    always_comb begin
        w_inflight_nxt = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            w_inflight_nxt = w_inflight_nxt + CW'(w_sr_nxt[i]);
        end
    end

    // A flush in ACTIVE empties the buffer on the same edge, which
    // also drops any read returning on that edge.
    always_comb begin
        w_valid     = (r_level != '0) && (r_state != S_DRAIN);
        w_pop       = w_valid && OUT_READY;
        w_flush_act = (r_state == S_ACTIVE) && FLUSH;
        w_cap       = r_sr[RD_LAT-1] && (r_state != S_DRAIN) &&
                      !w_flush_act;
        if (w_flush_act) begin
            w_level_nxt = '0;
        end else begin
            w_level_nxt = r_level + LW'(w_cap) - LW'(w_pop);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_state_nxt = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (FLUSH) begin
                    w_state_nxt = S_DRAIN;
                end else if (w_inflight_nxt == '0 &&
                             w_level_nxt == '0 && !w_req) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (w_inflight_nxt == '0) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_sr     <= '0;
            r_level  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_sr    <= w_sr_nxt;
            r_level <= w_level_nxt;
            if (w_flush_act) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_cap) begin
                    r_buf[r_wr_ptr] <= FIFO_C;
                    r_wr_ptr        <= ptr_inc(r_wr_ptr);
                end
                if (w_pop) begin
                    r_rd_ptr <= ptr_inc(r_rd_ptr);
                end
            end
        end
    end

    assign FIFO_REQ  = w_req;
    assign OUT_VALID = w_valid;
    assign OUT_DATA  = r_buf[r_rd_ptr];
    assign OUT_LEVEL = r_level;
    assign BUSY      = (r_state != S_IDLE);

endmodule
